// File: rtl/resp_serializer.sv
// resp_serializer: sends one response word of up to MAX_BYTES bytes to
// uart_tx, LSB first, using the uart_tx data/ready/done handshake, then
// pulses done once the last byte has completed.
module resp_serializer #(
  parameter int MAX_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [8*MAX_BYTES-1:0] word,
  input  logic [3:0]             len,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             tx_data,
  output logic                   tx_data_ready,
  input  logic                   tx_done
);

  localparam int W  = 8 * MAX_BYTES;
  // remaining must be able to hold MAX_BYTES itself
  localparam int RW = $clog2(MAX_BYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_FIN
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [W-1:0]    shreg_nxt;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_done_q, tx_done_d;
  logic            tx_done_rise;
  logic [RW-1:0]   eff_len;

  // Edge detect on tx_done so both pulse and level forms advance once per byte
  assign tx_done_d    = tx_done;
  assign tx_done_rise = tx_done & ~tx_done_q;
  assign shreg_nxt    = shreg_q >> 8;

  // Clamp requested length to what the word can carry
  always_comb begin
    eff_len = RW'(len);
    if (32'(len) > MAX_BYTES) eff_len = RW'(MAX_BYTES);
  end

  // Next-state logic; tx_data is held unless a new byte is being presented
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    shreg_d   = shreg_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (eff_len != '0) begin
            shreg_d   = word;
            rem_d     = eff_len;
            tx_data_d = word[7:0];
            state_d   = S_SEND;
          end else begin
            state_d   = S_FIN;
          end
        end
      end
      // The strobe is exactly the one cycle spent here
      S_SEND: state_d = S_WAIT;
      // A rise that landed in SEND is deliberately not remembered
      S_WAIT: begin
        if (tx_done_rise) begin
          if (rem_q > RW'(1)) begin
            rem_d     = rem_q - RW'(1);
            shreg_d   = shreg_nxt;
            tx_data_d = shreg_nxt[7:0];
            state_d   = S_SEND;
          end else begin
            rem_d     = '0;
            state_d   = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any partial response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      shreg_q   <= '0;
      tx_data_q <= 8'h00;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      shreg_q   <= shreg_d;
      tx_data_q <= tx_data_d;
      tx_done_q <= tx_done_d;
    end
  end

  // Outputs decode directly from state so reset cuts them immediately
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FIN);
  assign tx_data_ready = (state_q == S_SEND);
  assign tx_data       = tx_data_q;

endmodule

// File: doc/resp_serializer.md
# resp_serializer

Multi-byte response serializer between the command handler's reply logic and `uart_tx`. It accepts one response word of up to `MAX_BYTES` bytes in a single-cycle `start` request. It hands the word to `uart_tx` one byte at a time, least-significant byte first, using the `uart_tx` data/ready/done handshake. It pulses `done` once the last byte has left the line, so `comm` can return replies such as the 32-bit pin map without sequencing bytes itself.

## Interface
- `MAX_BYTES`, default 4: maximum bytes per response; `word` is `8*MAX_BYTES` bits wide.
- `clk` input 1: system clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request; sampled only in IDLE.
- `word` input 8*MAX_BYTES: response payload; byte i = `word[8*i +: 8]`.
- `len` input 4: number of bytes to send; 0 = none; values above `MAX_BYTES` clamp to `MAX_BYTES`.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse when the response is complete.
- `tx_data` output 8: byte presented to `uart_tx`.
- `tx_data_ready` output 1: one-cycle strobe to `uart_tx`.
- `tx_done` input 1: completion indication from `uart_tx`; may be a pulse or a level.

## Operation
- Reset values: state=IDLE, `busy`=0, `done`=0, `tx_data`=8'h00, `tx_data_ready`=0, byte counter=0, shift register=0, `tx_done_q`=0.
- `tx_done_q` registers `tx_done` every cycle. A byte completes on `tx_done_rise` = `tx_done & ~tx_done_q`. This covers both pulse and level forms of `tx_done`.
- IDLE:
  - With `start`=1 and effective len ≥1: latch `word` into the shift register and the effective len into `remaining`, drive `tx_data`=byte 0, assert `tx_data_ready`, go to SEND.
  - With `start`=1 and len=0: go to FIN. No strobe is issued.
- SEND: lasts exactly one cycle. Deassert `tx_data_ready`, go to WAIT. `tx_data` is held.
- WAIT: on `tx_done_rise`:
  - If `remaining`>1: decrement `remaining`, shift the register right by 8, drive the next byte on `tx_data`, assert `tx_data_ready`, go to SEND.
  - If `remaining`==1: set `remaining`=0, go to FIN.
  - With no edge: stay in WAIT. There is no timeout.
- FIN: `done`=1 for this one cycle, then go to IDLE.
- `start` outside IDLE is ignored. `word` and `len` are not re-sampled mid-response.
- `tx_data` holds its last value after completion. It is not cleared.
- A `tx_done_rise` seen in IDLE, SEND or FIN is ignored. A rise in the SEND cycle is not remembered.
- Clamp: effective len = min(`len`, `MAX_BYTES`). `remaining` is wide enough for `MAX_BYTES`.

## Timing
- `start` sampled at edge k. `tx_data_ready`=1 during cycle k..k+1, with byte 0 on `tx_data`. SEND→WAIT at edge k+1.
- Each following byte: strobe appears the cycle after the edge that sampled `tx_done_rise`.
- `done` rises at the edge after the last `tx_done_rise` and lasts one cycle. `busy` falls one edge later.
- len=0: `busy` is high for exactly 1 cycle and `done` pulses in that same cycle (FIN). The earliest next `start` is accepted 2 cycles after the first.
- Back-to-back: a `start` held high during the `done` cycle is not taken. It is accepted in the following IDLE cycle.
- `rst_n` low at any time: all outputs return to reset values immediately and asynchronously. An in-flight `tx_data_ready` is cut. The partial response is dropped with no `done`.

## Test plan
- `word`=32'haabbccdd, `len`=4, looped into `uart_tx`→`uart_rx` with CLK_PER_BIT=16 -> receiver sees dd, cc, bb, aa in order; exactly one `done`; 4 `tx_data_ready` strobes, each 1 cycle wide.
- `len`=1, `word`=32'h12345678 -> single byte 78; `done` one cycle after its `tx_done_rise`.
- `len`=0 -> no strobe; `busy` and `done` each high for exactly 1 cycle; `busy` returns to 0.
- `len`=9 with MAX_BYTES=4 -> 4 bytes sent, matching the `len`=4 case.
- `start` pulsed with `word`=32'h0 mid-response to 32'haabbccdd -> ignored; output stays dd, cc, bb, aa. A `tx_done` level held high across bytes advances the serializer only on rising edges.
- `rst_n` dropped during WAIT of byte 2 -> `busy`/`tx_data_ready`/`done`=0 immediately. Then a new `start` with `len`=2, `word`=16'hbeef -> ef, be.
